// File: rtl/frame_gearbox_pkg.sv
// Shared readout definitions for the frame gearbox and the downstream scrambler.
// Contents: frame/buffer widths, the filler frame pattern, the dataWidth
// encodings and a helper that maps an encoding to its word width in bits.
package frame_gearbox_pkg;

   localparam int unsigned FRAME_WIDTH = 40;
   localparam int unsigned BUF_WIDTH   = 72;

   localparam logic [FRAME_WIDTH-1:0] FILLER_FRAME = 40'h3C5C000000;

   // dataWidth encodings; 2'b11 is an alias for 32 bits.
   typedef enum logic [1:0] {
      DwBits8     = 2'b00,
      DwBits16    = 2'b01,
      DwBits32    = 2'b10,
      DwBits32Alt = 2'b11
   } data_width_e;

   localparam logic [1:0] DW_RESET = 2'b10;

   function automatic logic [6:0] width_of(input logic [1:0] enc);
      logic [6:0] w;
      case (enc)
         DwBits8:  w = 7'd8;
         DwBits16: w = 7'd16;
         default:  w = 7'd32;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset, clears the count
//   inc_i   - count one event this cycle
//   count_o - registered count, sticks at 16'hFFFF
module sat_counter16 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= 16'h0000;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/frame_gearbox.sv
// Frame gearbox: serialises 40-bit ETROC2 frames (bit 0 first) into 8/16/32-bit
// words for the scrambler, inserting a filler frame whenever a frame is needed
// and none is offered.
// Ports:
//   clk        - word-rate clock
//   reset      - asynchronous active-low reset
//   dataWidth  - output word width select (00=8, 01=16, 1x=32)
//   frameIn    - frame to send, bit 0 first
//   frameValid - frameIn holds a frame
//   frameReady - a frame (or filler) is consumed this cycle
//   dout       - registered output word, LSB first, zero above the word width
//   fillerCnt  - saturating count of inserted filler frames
module frame_gearbox
   import frame_gearbox_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             dataWidth,
   input  logic [FRAME_WIDTH-1:0] frameIn,
   input  logic                   frameValid,
   output logic                   frameReady,
   output logic [31:0]            dout,
   output logic [15:0]            fillerCnt
);

   logic [BUF_WIDTH-1:0]   buf_q, buf_d, appended;
   logic [6:0]             cnt_q, cnt_d;
   logic [1:0]             w_reg_q;
   logic [31:0]            dout_q, dout_d;
   logic [6:0]             w;
   logic                   need, flush, consume, filler_ins;
   logic [FRAME_WIDTH-1:0] src;

   always_comb begin
      w        = width_of(w_reg_q);
      flush    = (dataWidth != w_reg_q);
      need     = (cnt_q < w);
      // Nothing is consumed while reset is held, so the upstream sees no handshake.
      consume  = need & ~flush & reset;
      src      = frameValid ? frameIn : FILLER_FRAME;
      appended = buf_q;
      if (consume) begin
         // cnt_q < 32 here, so the new frame always fits in the 72-bit buffer.
         appended = buf_q | ({{(BUF_WIDTH - FRAME_WIDTH){1'b0}}, src} << cnt_q);
      end

      case (w_reg_q)
         DwBits8:  dout_d = {24'h0, appended[7:0]};
         DwBits16: dout_d = {16'h0, appended[15:0]};
         default:  dout_d = appended[31:0];
      endcase
      buf_d = appended >> w;
      cnt_d = cnt_q + (consume ? 7'(FRAME_WIDTH) : 7'd0) - w;

      // A width change discards everything buffered and emits one zero word.
      if (flush) begin
         buf_d  = '0;
         cnt_d  = 7'd0;
         dout_d = 32'h0;
      end
      filler_ins = consume & ~frameValid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q   <= '0;
         cnt_q   <= 7'd0;
         dout_q  <= 32'h0;
         w_reg_q <= DW_RESET;
      end else begin
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         w_reg_q <= dataWidth;
      end
   end

   sat_counter16 u_filler_cnt (
      .clk_i   (clk),
      .rst_ni  (reset),
      .inc_i   (filler_ins),
      .count_o (fillerCnt)
   );

   assign frameReady = consume;
   assign dout       = dout_q;

endmodule

// File: tb/tb_frame_gearbox.sv
// Bench for frame_gearbox: directed scenarios plus randomized traffic, checked
// against a bit-queue reference model of the gearbox.
module tb_frame_gearbox;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  dataWidth;
   logic [39:0] frameIn;
   logic        frameValid;
   logic        frameReady;
   logic [31:0] dout;
   logic [15:0] fillerCnt;

   int errors = 0;
   int checks = 0;

   localparam logic [39:0] FILLER = 40'h3C5C000000;

   always #5 clk = ~clk;

   frame_gearbox dut (
      .clk        (clk),
      .reset      (reset),
      .dataWidth  (dataWidth),
      .frameIn    (frameIn),
      .frameValid (frameValid),
      .frameReady (frameReady),
      .dout       (dout),
      .fillerCnt  (fillerCnt)
   );

   // Reference model: a FIFO of bits, oldest first.
   bit          mq[$];
   logic [1:0]  m_w;
   int          m_fill;
   int          m_ins;
   logic [31:0] m_dout;
   bit          m_ready;
   bit          o_ready;
   bit          chk_en = 1'b1;

   function automatic int wbits(input logic [1:0] e);
      if (e == 2'b00) return 8;
      if (e == 2'b01) return 16;
      return 32;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_w    = 2'b10;
      m_fill = 0;
      m_dout = 32'h0;
   endtask

   // One clock cycle: checks frameReady before the edge, dout/fillerCnt after it.
   task automatic step();
      bit          flush;
      bit          need;
      int          w;
      logic [39:0] src;
      @(negedge clk);
      flush   = (dataWidth !== m_w);
      w       = wbits(m_w);
      need    = !flush && (mq.size() < w);
      m_ready = need;
      o_ready = frameReady;
      if (chk_en) check("frameReady", 32'(frameReady), 32'(need));
      @(posedge clk);
      if (flush) begin
         mq.delete();
         m_w    = dataWidth;
         m_dout = 32'h0;
      end else begin
         if (need) begin
            src = frameValid ? frameIn : FILLER;
            for (int i = 0; i < 40; i++) mq.push_back(src[i]);
            if (!frameValid) begin
               m_ins++;
               if (m_fill < 65535) m_fill++;
            end
         end
         m_dout = 32'h0;
         for (int i = 0; i < w; i++) m_dout[i] = mq.pop_front();
      end
      #1;
      if (chk_en) begin
         check("dout", dout, m_dout);
         check("fillerCnt", 32'(fillerCnt), 32'(m_fill));
      end
   endtask

   // Asserts reset mid-cycle, checks outputs clear at once, releases after one edge.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_dout", dout, 32'h0);
      check("rst_fillerCnt", 32'(fillerCnt), 32'h0);
      check("rst_frameReady", 32'(frameReady), 32'h0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic rand_frame();
      logic [63:0] r;
      r       = {$urandom, $urandom};
      frameIn = r[39:0];
   endtask

   initial begin
      logic [7:0] exp_bytes[10];
      bit         pat[10];
      logic [39:0] f;
      int          guard;

      reset      = 1'b0;
      dataWidth  = 2'b10;
      frameIn    = 40'h0;
      frameValid = 1'b0;
      model_reset();
      m_ins = 0;
      @(posedge clk);
      #1;
      check("reset_dout", dout, 32'h0);
      check("reset_fillerCnt", 32'(fillerCnt), 32'h0);
      check("reset_frameReady", 32'(frameReady), 32'h0);
      reset = 1'b1;

      // Two back-to-back frames at 32 bits.
      frameIn = 40'h1122334455; frameValid = 1'b1;
      step();
      check("w32_word0", dout, 32'h22334455);
      frameIn = 40'hAABBCCDDEE;
      step();
      check("w32_word1", dout, 32'hCCDDEE11);

      // Ready cadence at 32 bits with a frame always offered.
      do_reset();
      dataWidth = 2'b10; frameValid = 1'b1;
      pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 10; i++) begin
         if (i == 0 || m_ready) rand_frame();
         step();
         check("ready_pattern", 32'(o_ready), 32'(pat[i]));
      end

      // Byte mode: one frame, then the filler.
      do_reset();
      dataWidth = 2'b00; frameValid = 1'b0;
      step();                       // width change from the reset encoding
      check("w8_flush_dout", dout, 32'h0);
      frameIn = 40'h0102030405; frameValid = 1'b1;
      exp_bytes = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h3C};
      for (int i = 0; i < 10; i++) begin
         step();
         frameValid = 1'b0;
         check("w8_byte", dout, {24'h0, exp_bytes[i]});
         if (i == 5) check("w8_filler_cnt", 32'(fillerCnt), 32'd1);
      end

      // Width switch 32 -> 8 with 16 bits buffered.
      do_reset();
      dataWidth = 2'b10; frameValid = 1'b1;
      rand_frame(); step();
      rand_frame(); step();
      dataWidth = 2'b00;
      rand_frame();
      f = frameIn;
      step();
      check("switch_dout", dout, 32'h0);
      check("switch_ready", 32'(o_ready), 32'h0);
      step();
      check("switch_ready2", 32'(o_ready), 32'h1);
      check("switch_first", dout, {24'h0, f[7:0]});

      // Reset with 24 bits buffered, then restart cleanly.
      do_reset();
      dataWidth = 2'b10; frameValid = 1'b1;
      for (int i = 0; i < 3; i++) begin rand_frame(); step(); end
      do_reset();
      rand_frame();
      f = frameIn;
      step();
      check("post_reset_first", dout, f[31:0]);

      // Randomized traffic with width changes and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if (!(frameValid && !m_ready)) begin
            rand_frame();
            frameValid = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 59) == 0) dataWidth = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) do_reset();
         step();
      end

      // Filler saturation.
      do_reset();
      dataWidth  = 2'b10;
      frameValid = 1'b0;
      m_ins      = 0;
      chk_en     = 1'b0;
      guard      = 0;
      while (m_ins < 65540 && guard < 90000) begin
         step();
         guard++;
      end
      chk_en = 1'b1;
      check("sat_reached_budget", 32'(m_ins), 32'd65540);
      check("sat_value", 32'(fillerCnt), 32'h0000FFFF);
      for (int i = 0; i < 10; i++) step();
      check("sat_hold", 32'(fillerCnt), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_gearbox.md
FRAME_GEARBOX -- requirements
Module: frame_gearbox

Interface
REQ-001 SHALL have no parameters; all widths and constants are fixed.
REQ-002 clk  input  1  word-rate clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dataWidth  input  2  output word width: 00 = 8, 01 = 16, 10/11 = 32 bits (W below).
REQ-005 frameIn  input  40  ETROC2 frame; bit 0 is transmitted first.
REQ-006 frameValid  input  1  frameIn holds a frame to send.
REQ-007 frameReady  output  1  combinational; a frame is consumed this cycle (frameIn if frameValid, else filler).
REQ-008 dout  output  32  registered word to the downstream scrambler, LSB first; bits above W are 0.
REQ-009 fillerCnt  output  16  registered saturating count of inserted filler frames.

Function
REQ-010 SHALL hold a 72-bit bit buffer buf and a 7-bit fill count cnt (0..71); valid bits are buf[cnt-1:0], oldest at bit 0.
REQ-011 SHALL set need = (cnt < W); frameReady SHALL equal need whenever no flush occurs (REQ-017).
REQ-012 When need = 1, SHALL append src at buf[cnt+39:cnt]; src = frameIn if frameValid = 1, else FILLER_FRAME.
REQ-013 When need = 0, frameIn SHALL NOT be consumed; the upstream holds frameIn and frameValid.
REQ-014 Every cycle, dout SHALL register the low W bits of the post-append buffer, zero-extended to 32 bits.
REQ-015 Every cycle, the buffer SHALL shift right by W, and cnt SHALL update to cnt + 40*need - W.
REQ-016 Output latency: the first bit of a frame consumed in cycle n SHALL appear on dout after the clock edge ending cycle n.
REQ-017 Width change: dataWidth SHALL be registered as wReg.
- When dataWidth != wReg, the block SHALL perform a flush: buf = 0, cnt = 0, dout = 0, wReg = dataWidth, frameReady = 0, and no frame is consumed.
REQ-018 Throughput: W=32 SHALL consume 4 frames per 5 cycles; W=16 SHALL consume 2 per 5; W=8 SHALL consume 1 per 5.
REQ-019 fillerCnt SHALL increment when need = 1 and frameValid = 0, and SHALL hold at 16'hFFFF.
REQ-020 frameValid high while frameReady is low SHALL have no effect on the block's state.

Reset
REQ-021 reset low SHALL asynchronously force buf = 0, cnt = 0, dout = 0, fillerCnt = 0 and wReg = 2'b10.
REQ-022 On the first cycle after reset release, cnt = 0 SHALL force need = 1; a frame or filler SHALL be consumed immediately.
REQ-023 Reset asserted mid-frame SHALL discard all buffered bits; no partial frame is emitted after release.

Structure
REQ-024 The shared readout package SHALL hold FRAME_WIDTH = 40, BUF_WIDTH = 72, FILLER_FRAME = 40'h3C5C000000 and the dataWidth encodings; the scrambler uses the same encodings.
REQ-025 A single sub-module, sat_counter16, SHALL implement fillerCnt; the remaining logic SHALL be flat.

Verification
REQ-026 W=32, continuous frames 40'h1122334455 then 40'hAABBCCDDEE -> dout = 32'h22334455, then 32'hCCDDEE11.
REQ-027 W=8, one frame 40'h0102030405 followed by frameValid=0:
- dout = 05, 04, 03, 02, 01;
- then the filler bytes 00, 00, 00, 5C, 3C;
- fillerCnt = 1 when the filler is consumed.
REQ-028 W=32 with frameValid held high -> frameReady pattern 1,1,1,1,0 repeating; cnt sequence 8, 16, 24, 32, 0.
REQ-029 Switch dataWidth from 10 to 00 while cnt = 16 -> one cycle with dout = 0 and frameReady = 0; the next cycle consumes a frame and dout carries its bits[7:0].
REQ-030 Assert reset mid-stream with cnt = 24 -> all outputs become 0 immediately; after release, the first dout is the low W bits of the next frame.
REQ-031 Force 65,540 filler insertions -> fillerCnt saturates at 16'hFFFF and holds there.
